window_stage_reg: RTL and testbench

WINDOW_STAGE_REG -- requirements
Module: window_stage_reg

---
 rtl/window_stage_reg.sv | 95 +++++++++
 tb/tb_window_stage_reg.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/window_stage_reg.sv
// Two-entry (main + skid) pipeline register for 3x3 window taps and output address.
// Optional output-transfer counter enabled by defining WINDOW_STAGE_XFER_CNT_EN.
module window_stage_reg #(
  parameter int PW        = 8,
  parameter int NTAP      = 9,
  parameter int AW        = 19,
  parameter int LAST_ADDR = 479999
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NTAP*PW-1:0] in_taps,
  input  logic [AW-1:0]      in_addr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NTAP*PW-1:0] out_taps,
  output logic [AW-1:0]      out_addr,
  output logic               out_last,
  output logic [31:0]        xfer_cnt
);

  logic               main_valid_reg;
  logic [NTAP*PW-1:0] main_taps_reg;
  logic [AW-1:0]      main_addr_reg;
  logic               skid_valid_reg;
  logic [NTAP*PW-1:0] skid_taps_reg;
  logic [AW-1:0]      skid_addr_reg;

  logic in_fire;
  logic out_fire;

  // in_ready comes straight from a register so out_ready never reaches upstream.
  assign in_ready  = ~skid_valid_reg;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = main_valid_reg;
  assign out_fire  = main_valid_reg & out_ready;
  assign out_taps  = main_taps_reg;
  assign out_addr  = main_addr_reg;
  assign out_last  = main_valid_reg & (main_addr_reg == AW'(LAST_ADDR));

  always_ff @(negedge clk) begin
    if (reset) begin
      main_valid_reg <= 1'b0;
      main_taps_reg  <= '0;
      main_addr_reg  <= '0;
      skid_valid_reg <= 1'b0;
      skid_taps_reg  <= '0;
      skid_addr_reg  <= '0;
    end else if (flush) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (out_fire) begin
      if (skid_valid_reg) begin
        main_taps_reg  <= skid_taps_reg;
        main_addr_reg  <= skid_addr_reg;
        skid_valid_reg <= 1'b0;
      end else if (in_fire) begin
        main_taps_reg  <= in_taps;
        main_addr_reg  <= in_addr;
      end else begin
        // Data is left in place; only the valid bit drops.
        main_valid_reg <= 1'b0;
      end
    end else if (in_fire) begin
      if (!main_valid_reg) begin
        main_valid_reg <= 1'b1;
        main_taps_reg  <= in_taps;
        main_addr_reg  <= in_addr;
      end else begin
        skid_valid_reg <= 1'b1;
        skid_taps_reg  <= in_taps;
        skid_addr_reg  <= in_addr;
      end
    end
  end

`ifdef WINDOW_STAGE_XFER_CNT_EN
  logic [31:0] xfer_cnt_reg;

  always_ff @(negedge clk) begin
    if (reset) begin
      xfer_cnt_reg <= '0;
    end else if (!flush && out_fire) begin
      xfer_cnt_reg <= xfer_cnt_reg + 32'd1;
    end
  end

  assign xfer_cnt = xfer_cnt_reg;
`else
  assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_window_stage_reg.sv
// Bench for window_stage_reg: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_window_stage_reg;
  localparam int PW        = 8;
  localparam int NTAP      = 9;
  localparam int AW        = 19;
  localparam int LAST_ADDR = 479999;
  localparam int TW        = PW * NTAP;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [TW-1:0] in_taps, out_taps;
  logic [AW-1:0] in_addr, out_addr;
  logic [31:0]   xfer_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: ordered queue of held entries {addr, taps}, plus the last shown data.
  logic [AW+TW-1:0] q[$];
  logic [TW-1:0]    m_taps;
  logic [AW-1:0]    m_addr;
  logic [31:0]      m_cnt;

  window_stage_reg #(.PW(PW), .NTAP(NTAP), .AW(AW), .LAST_ADDR(LAST_ADDR)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_taps(in_taps), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_taps(out_taps),
    .out_addr(out_addr), .out_last(out_last), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef WINDOW_STAGE_XFER_CNT_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic compare_all();
    logic mv;
    mv = (q.size() > 0);
    chk("out_valid", 128'(out_valid), 128'(mv));
    chk("in_ready",  128'(in_ready),  128'(q.size() < 2));
    chk("out_addr",  128'(out_addr),  128'(m_addr));
    chk("out_taps",  128'(out_taps),  128'(m_taps));
    chk("out_last",  128'(out_last),  128'(mv && (m_addr == AW'(LAST_ADDR))));
    chk("xfer_cnt",  128'(xfer_cnt),  128'(exp_cnt()));
  endtask

  // Drive one cycle of inputs, advance the model across the falling edge, then check.
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [TW-1:0] t, input logic [AW-1:0] a, input logic ordy);
    logic ofire, ifire;
    reset = r; flush = f; in_valid = iv; in_taps = t; in_addr = a; out_ready = ordy;
    if (r) begin
      q.delete(); m_taps = '0; m_addr = '0; m_cnt = '0;
    end else if (f) begin
      q.delete();
    end else begin
      ofire = (q.size() > 0) && ordy;
      ifire = iv && (q.size() < 2);
      if (ofire) begin
        void'(q.pop_front());
        m_cnt = m_cnt + 32'd1;
      end
      if (ifire) q.push_back({a, t});
      if (q.size() > 0) begin
        m_addr = q[0][AW+TW-1:TW];
        m_taps = q[0][TW-1:0];
      end
    end
    @(posedge clk);
    compare_all();
  endtask

  function automatic logic [TW-1:0] rnd_taps();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[TW-1:0];
  endfunction

  initial begin
    logic [TW-1:0] seq_taps;
    logic [31:0]   saved_cnt;
    logic [AW-1:0] ra;
    m_taps = '0; m_addr = '0; m_cnt = '0;

    step(1, 0, 0, '0, '0, 0);
    step(1, 1, 1, rnd_taps(), 19'd7, 1);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_taps",  128'(out_taps),  128'(0));
    chk("rst_in_ready",  128'(in_ready),  128'(1));

    // First entry appears one cycle after acceptance, taps bit-exact.
    for (int k = 0; k < NTAP; k++) seq_taps[k*PW +: PW] = PW'(k + 1);
    step(0, 0, 1, seq_taps, 19'd5, 1);
    chk("lit_first_valid", 128'(out_valid), 128'(1));
    chk("lit_first_addr",  128'(out_addr),  128'(5));
    chk("lit_first_taps",  128'(out_taps),  128'(72'h090807060504030201));
    step(0, 0, 0, '0, '0, 1);

    // Back-pressure fills the skid, then drains in order.
    step(0, 0, 1, rnd_taps(), 19'd10, 0);
    step(0, 0, 1, rnd_taps(), 19'd11, 0);
    chk("lit_skid_in_ready", 128'(in_ready), 128'(0));
    chk("lit_skid_addr10",   128'(out_addr), 128'(10));
    step(0, 0, 0, '0, '0, 1);
    chk("lit_drain_addr11", 128'(out_addr), 128'(11));
    chk("lit_drain_ready",  128'(in_ready), 128'(1));
    step(0, 0, 0, '0, '0, 1);
    chk("lit_drain_empty", 128'(out_valid), 128'(0));

    // Continuous stream: one output per cycle with no bubbles.
    step(1, 0, 0, '0, '0, 0);
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 1, rnd_taps(), AW'(i), 1);
      chk("lit_stream_addr", 128'(out_addr), 128'(i));
    end
    step(0, 0, 0, '0, '0, 1);
`ifdef WINDOW_STAGE_XFER_CNT_EN
    chk("lit_stream_cnt", 128'(xfer_cnt), 128'(100));
`else
    chk("lit_stream_cnt", 128'(xfer_cnt), 128'(0));
`endif

    // Final-address flag.
    step(0, 0, 1, rnd_taps(), 19'd479999, 0);
    chk("lit_last_hi", 128'(out_last), 128'(1));
    step(0, 0, 0, '0, '0, 1);
    chk("lit_last_gone", 128'(out_last), 128'(0));
    step(0, 0, 1, rnd_taps(), 19'd479998, 0);
    chk("lit_last_lo", 128'(out_last), 128'(0));
    step(0, 0, 0, '0, '0, 1);

    // Flush with both entries held.
    step(0, 0, 1, rnd_taps(), 19'd20, 0);
    step(0, 0, 1, rnd_taps(), 19'd21, 0);
    saved_cnt = m_cnt;
    step(0, 1, 1, rnd_taps(), 19'd22, 1);
    chk("lit_flush_valid", 128'(out_valid), 128'(0));
    chk("lit_flush_ready", 128'(in_ready),  128'(1));
    chk("lit_flush_cnt",   128'(m_cnt),     128'(saved_cnt));

    // Reset beats flush and transfers.
    step(0, 0, 1, rnd_taps(), 19'd30, 0);
    step(0, 0, 1, rnd_taps(), 19'd31, 0);
    step(1, 1, 1, rnd_taps(), 19'd32, 1);
    chk("lit_rst_addr",  128'(out_addr), 128'(0));
    chk("lit_rst_taps",  128'(out_taps), 128'(0));
    chk("lit_rst_last",  128'(out_last), 128'(0));
    chk("lit_rst_cnt",   128'(xfer_cnt), 128'(0));

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      ra = ($urandom_range(0, 15) == 0) ? AW'(LAST_ADDR) : AW'($urandom_range(0, 479999));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) < 7), rnd_taps(), ra, ($urandom_range(0, 9) < 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
